// File: rtl/fpu_req_sequencer.sv
// Issue stage in front of the fixed-latency fpu: registers requests onto the
// fpu pins, tracks in-flight ops and buffers results in a credit-guarded FIFO.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready                request handshake
//   in_rmode/op/opa/opb/tag          request payload
//   fpu_rmode/op/opa/opb             registered fpu inputs
//   fpu_out, fpu_flags               fpu results, sampled LATENCY edges later
//   out_valid/out_ready              result handshake (FIFO head)
//   out_result/out_flags/out_tag     head entry
//   issued_cnt, completed_cnt        wrapping accept/pop counters
module fpu_req_sequencer #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_rmode,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_opa,
  input  logic [31:0]      in_opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic [1:0]       fpu_rmode,
  output logic [2:0]       fpu_op,
  output logic [31:0]      fpu_opa,
  output logic [31:0]      fpu_opb,
  input  logic [31:0]      fpu_out,
  input  logic [7:0]       fpu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [7:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      completed_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int IFW  = $clog2(LATENCY + 1);
  localparam int CW   = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] sr_v;
  logic [TAG_W-1:0]   sr_tag [LATENCY];

  logic [IFW-1:0]  infl;
  logic [CNTW-1:0] cnt;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;

  logic [31:0]      mem_res [DEPTH];
  logic [7:0]       mem_flg [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [31:0]      hold_res;
  logic [7:0]       hold_flg;
  logic [TAG_W-1:0] hold_tag;

  logic accept;
  logic cap;
  logic pop;
  logic [CW-1:0] used;

  // Credit counts every op from accept until its result is popped, so the
  // FIFO always has a free slot by the time a result reaches the last stage.
  assign used      = CW'(cnt) + CW'(infl);
  assign in_ready  = rst_n & (used < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign cap       = sr_v[LATENCY-1];
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;

  assign out_result = out_valid ? mem_res[rp] : hold_res;
  assign out_flags  = out_valid ? mem_flg[rp] : hold_flg;
  assign out_tag    = out_valid ? mem_tag[rp] : hold_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_rmode     <= '0;
      fpu_op        <= '0;
      fpu_opa       <= '0;
      fpu_opb       <= '0;
      sr_v          <= '0;
      for (int i = 0; i < LATENCY; i++) sr_tag[i] <= '0;
      infl          <= '0;
      cnt           <= '0;
      wp            <= '0;
      rp            <= '0;
      hold_res      <= '0;
      hold_flg      <= '0;
      hold_tag      <= '0;
      issued_cnt    <= '0;
      completed_cnt <= '0;
    end else begin
      if (accept) begin
        fpu_rmode  <= in_rmode;
        fpu_op     <= in_op;
        fpu_opa    <= in_opa;
        fpu_opb    <= in_opb;
        issued_cnt <= issued_cnt + 16'd1;
      end

      for (int i = LATENCY - 1; i > 0; i--) begin
        sr_v[i]   <= sr_v[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
      sr_v[0]   <= accept;
      sr_tag[0] <= in_tag;

      unique case ({accept, cap})
        2'b10:   infl <= infl + IFW'(1);
        2'b01:   infl <= infl - IFW'(1);
        default: ;
      endcase

      unique case ({cap, pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: ;
      endcase

      if (cap) wp <= wp + PW'(1);

      if (pop) begin
        rp            <= rp + PW'(1);
        hold_res      <= mem_res[rp];
        hold_flg      <= mem_flg[rp];
        hold_tag      <= mem_tag[rp];
        completed_cnt <= completed_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (rst_n && cap) begin
      mem_res[wp] <= fpu_out;
      mem_flg[wp] <= fpu_flags;
      mem_tag[wp] <= sr_tag[LATENCY-1];
    end
  end

endmodule
